uart_host_master: RTL and testbench

// Register-bus initiator that drives the CPU-side register port of the UART host controller (CTRL/STAT/DATA).

---
 rtl/uart_host_master.sv | 182 ++++++++++++++++++
 tb/tb_uart_host_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_master.sv
// Register-bus initiator for the UART host controller: polls STAT, writes CTRL/DATA,
// and bridges DATA reads/writes to valid/ready byte streams.
module uart_host_master #(
   parameter logic [7:0] CTRL_INIT = 8'h04,
   parameter int unsigned POLL_GAP  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] cfg_ctrl_i,
   input  logic       cfg_load_i,
   input  logic       err_clr_i,
   output logic       err_parity_o,
   output logic       err_frame_o,
   output logic       cts_o,
   output logic [7:0] reg_d_o,
   input  logic [7:0] reg_d_i,
   output logic       reg_wr_o,
   output logic       reg_rd_o,
   output logic       reg_cs_ctrl_o,
   output logic       reg_cs_stat_o,
   output logic       reg_cs_data_o
);

   typedef enum logic [2:0] {
      StCfgWr, StPoll, StDecide, StErrClr, StRxRd, StTxWr, StGap
   } state_e;

   localparam logic [7:0] GapLast  = 8'(POLL_GAP - 1);
   localparam state_e     AfterAcc = (POLL_GAP == 0) ? StPoll : StGap;

   state_e     state_q, state_d;
   logic [7:0] cfg_pend_q, cfg_pend_d;
   logic       cfg_flag_q, cfg_flag_d;
   logic [7:0] stat_q, stat_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       err_parity_q, err_parity_d;
   logic       err_frame_q, err_frame_d;
   logic       last_tx_q, last_tx_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;
   logic       rx_elig, tx_elig, err_elig;
   logic       unused_stat;

   assign unused_stat = ^stat_q[2:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StCfgWr;
         cfg_pend_q   <= CTRL_INIT;
         cfg_flag_q   <= 1'b1;
         stat_q       <= 8'h84;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
         last_tx_q    <= 1'b1;
         gap_cnt_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         cfg_pend_q   <= cfg_pend_d;
         cfg_flag_q   <= cfg_flag_d;
         stat_q       <= stat_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         err_parity_q <= err_parity_d;
         err_frame_q  <= err_frame_d;
         last_tx_q    <= last_tx_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign rx_elig  = !stat_q[7] && !rx_valid_q;
   assign tx_elig  = tx_valid_i && !stat_q[3];
   assign err_elig = stat_q[5] | stat_q[4];

   always_comb begin
      state_d      = state_q;
      cfg_pend_d   = cfg_load_i ? cfg_ctrl_i : cfg_pend_q;
      cfg_flag_d   = cfg_flag_q | cfg_load_i;
      stat_d       = stat_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q && !rx_ready_i;
      err_parity_d = err_parity_q && !err_clr_i;
      err_frame_d  = err_frame_q && !err_clr_i;
      last_tx_d    = last_tx_q;
      gap_cnt_d    = 8'h00;
      unique case (state_q)
         StCfgWr: begin
            // A load landing on the completing write keeps the new value pending.
            cfg_flag_d = cfg_load_i;
            state_d    = AfterAcc;
         end
         StPoll: begin
            stat_d  = reg_d_i;
            state_d = StDecide;
         end
         StDecide: begin
            if (cfg_flag_q) begin
               state_d = StCfgWr;
            end else if (err_elig) begin
               state_d = StErrClr;
               if (stat_q[5]) err_parity_d = 1'b1;
               if (stat_q[4]) err_frame_d = 1'b1;
            end else if (rx_elig && (!tx_elig || last_tx_q)) begin
               state_d = StRxRd;
            end else if (tx_elig) begin
               state_d = StTxWr;
            end else begin
               state_d = StPoll;
            end
         end
         StErrClr: state_d = AfterAcc;
         StRxRd: begin
            rx_data_d  = reg_d_i;
            rx_valid_d = 1'b1;
            last_tx_d  = 1'b0;
            state_d    = AfterAcc;
         end
         StTxWr: begin
            last_tx_d = 1'b1;
            state_d   = AfterAcc;
         end
         StGap: begin
            if (gap_cnt_q == GapLast) state_d = StPoll;
            else gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: state_d = StCfgWr;
      endcase
   end

   // Bus strobes are gated by reset so nothing is driven while reset is held.
   always_comb begin
      reg_wr_o      = 1'b0;
      reg_rd_o      = 1'b0;
      reg_cs_ctrl_o = 1'b0;
      reg_cs_stat_o = 1'b0;
      reg_cs_data_o = 1'b0;
      reg_d_o       = 8'h00;
      tx_ready_o    = 1'b0;
      if (!reset) begin
         case (state_q)
            StCfgWr: begin
               reg_wr_o      = 1'b1;
               reg_cs_ctrl_o = 1'b1;
               reg_d_o       = cfg_pend_q;
            end
            StPoll: begin
               reg_rd_o      = 1'b1;
               reg_cs_stat_o = 1'b1;
            end
            StErrClr: begin
               reg_wr_o      = 1'b1;
               reg_cs_stat_o = 1'b1;
            end
            StRxRd: begin
               reg_rd_o      = 1'b1;
               reg_cs_data_o = 1'b1;
            end
            StTxWr: begin
               reg_wr_o      = 1'b1;
               reg_cs_data_o = 1'b1;
               reg_d_o       = tx_data_i;
               tx_ready_o    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rx_data_o    = rx_data_q;
   assign rx_valid_o   = rx_valid_q;
   assign err_parity_o = err_parity_q;
   assign err_frame_o  = err_frame_q;
   assign cts_o        = stat_q[6];

endmodule

// File: tb/tb_uart_host_master.sv
// Bench for uart_host_master: a behavioural slave plus TX/RX scoreboards, round-robin order
// and error/config checks.
module tb_uart_host_master;

   logic       clk, reset;
   logic [7:0] tx_data_i;
   logic       tx_valid_i, tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, rx_ready_i;
   logic [7:0] cfg_ctrl_i;
   logic       cfg_load_i, err_clr_i;
   logic       err_parity_o, err_frame_o, cts_o;
   logic [7:0] reg_d_o, reg_d_i;
   logic       reg_wr_o, reg_rd_o, reg_cs_ctrl_o, reg_cs_stat_o, reg_cs_data_o;

   logic [7:0] stat_val, rx_byte;
   int         n_checks, n_errors;
   int         tx_idx, tx_cnt, rd_cnt;
   logic       last_poll;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   logic [7:0] seq[$];

   uart_host_master dut (
      .clk          (clk),
      .reset        (reset),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .rx_ready_i   (rx_ready_i),
      .cfg_ctrl_i   (cfg_ctrl_i),
      .cfg_load_i   (cfg_load_i),
      .err_clr_i    (err_clr_i),
      .err_parity_o (err_parity_o),
      .err_frame_o  (err_frame_o),
      .cts_o        (cts_o),
      .reg_d_o      (reg_d_o),
      .reg_d_i      (reg_d_i),
      .reg_wr_o     (reg_wr_o),
      .reg_rd_o     (reg_rd_o),
      .reg_cs_ctrl_o(reg_cs_ctrl_o),
      .reg_cs_stat_o(reg_cs_stat_o),
      .reg_cs_data_o(reg_cs_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational slave read port.
   always_comb reg_d_i = reg_cs_data_o ? rx_byte : stat_val;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0: return reg_wr_o && reg_cs_ctrl_o;
         1: return reg_rd_o && reg_cs_data_o;
         2: return reg_wr_o && reg_cs_data_o;
         3: return reg_wr_o && reg_cs_stat_o;
         default: return err_parity_o;
      endcase
   endfunction

   // Returns at the first negedge where the condition holds.
   task automatic wait_until(input int sel, input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cond(sel)) return;
      end
      check(tag, 0, 1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      tx_exp.push_back(b);
      wait_until(2, "tx_accept_timeout");
      @(posedge clk); #1;
      tx_valid_i = 1'b0;
   endtask

   task automatic monitor();
      logic [2:0] cs;
      forever begin
         @(negedge clk);
         if (reset) begin
            last_poll = 1'b0;
            seq.delete();
            rx_exp.delete();
         end else begin
            cs = {reg_cs_ctrl_o, reg_cs_stat_o, reg_cs_data_o};
            check("tx_ready", {31'd0, tx_ready_o}, {31'd0, reg_wr_o & reg_cs_data_o});
            if (cs == 3'b000) begin
               check("idle_bus", {22'd0, reg_wr_o, reg_rd_o, reg_d_o}, 0);
            end else begin
               check("cs_onehot", $countones(cs), 1);
               check("one_strobe", {31'd0, reg_wr_o ^ reg_rd_o}, 1);
               if (reg_cs_data_o && reg_wr_o) begin
                  check("tx_after_poll", {31'd0, last_poll}, 1);
                  if (tx_idx < tx_exp.size()) check("tx_data", {24'd0, reg_d_o},
                                                    {24'd0, tx_exp[tx_idx]});
                  else check("tx_unexpected", 1, 0);
                  tx_idx++;
                  tx_cnt++;
                  seq.push_back("T");
               end
               if (reg_cs_data_o && reg_rd_o) begin
                  check("rx_after_poll", {31'd0, last_poll}, 1);
                  rx_exp.push_back(reg_d_i);
                  rd_cnt++;
                  seq.push_back("R");
               end
               last_poll = reg_cs_stat_o && reg_rd_o;
            end
            if (rx_valid_o && rx_ready_i) begin
               if (rx_exp.size() > 0) check("rx_data", {24'd0, rx_data_o},
                                            {24'd0, rx_exp.pop_front()});
               else check("rx_unexpected", 1, 0);
            end
         end
      end
   endtask

   task automatic stimulus();
      int w0, r0;
      reset = 1'b1; tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
      cfg_ctrl_i = 8'h00; cfg_load_i = 1'b0; err_clr_i = 1'b0;
      stat_val = 8'h84; rx_byte = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_bus", {19'd0, reg_wr_o, reg_rd_o, reg_cs_ctrl_o, reg_cs_stat_o,
                        reg_cs_data_o, reg_d_o}, 0);
      check("rst_flags", {27'd0, tx_ready_o, rx_valid_o, err_parity_o, err_frame_o, cts_o}, 0);
      check("rst_rx_data", {24'd0, rx_data_o}, 0);

      // Release with a config load landing on the first CTRL write.
      @(posedge clk); #1;
      reset = 1'b0; cfg_ctrl_i = 8'h5A; cfg_load_i = 1'b1;
      @(negedge clk);
      check("cyc0_strb", {27'd0, reg_wr_o, reg_rd_o, reg_cs_ctrl_o, reg_cs_stat_o,
                          reg_cs_data_o}, 5'b10100);
      check("cyc0_data", {24'd0, reg_d_o}, 8'h04);
      @(posedge clk); #1;
      cfg_load_i = 1'b0;
      @(negedge clk);
      check("cyc1_poll", {27'd0, reg_wr_o, reg_rd_o, reg_cs_ctrl_o, reg_cs_stat_o,
                          reg_cs_data_o}, 5'b01010);
      @(negedge clk);
      @(negedge clk);
      check("cfg_rewrite", {23'd0, reg_wr_o, reg_cs_ctrl_o, reg_d_o}, {23'd0, 2'b11, 8'h5A});

      // TX with room in the FIFO.
      @(posedge clk); #1;
      send_byte(8'h55);
      @(negedge clk);
      check("tx_ready_1cyc", {31'd0, tx_ready_o}, 0);

      // TX held off while the FIFO reports full.
      stat_val = 8'h88;
      repeat (4) @(posedge clk); #1;
      w0 = tx_cnt;
      tx_data_i = 8'h66; tx_valid_i = 1'b1; tx_exp.push_back(8'h66);
      repeat (20) @(posedge clk); #1;
      check("tx_full_hold", tx_cnt - w0, 0);
      stat_val = 8'h84;
      wait_until(2, "tx_resume_timeout");
      @(posedge clk); #1;
      tx_valid_i = 1'b0;

      // RX with backpressure.
      stat_val = 8'h04; rx_byte = 8'hA5;
      wait_until(1, "rx_rd_timeout");
      @(posedge clk); #1;
      rx_byte = 8'h3C;
      r0 = rd_cnt;
      @(negedge clk);
      check("rx_valid", {31'd0, rx_valid_o}, 1);
      check("rx_first", {24'd0, rx_data_o}, 8'hA5);
      repeat (20) @(posedge clk); #1;
      check("rx_hold", rd_cnt - r0, 0);
      rx_ready_i = 1'b1;
      @(posedge clk); #1;
      rx_ready_i = 1'b0;
      wait_until(1, "rx_next_timeout");
      @(posedge clk); #1;
      stat_val = 8'h84; rx_ready_i = 1'b1;
      repeat (6) @(posedge clk); #1;
      rx_ready_i = 1'b0;
      check("rx_drained", {31'd0, rx_valid_o}, 0);

      // Reset, then RX and TX both eligible: round-robin starting with RX.
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0; stat_val = 8'h04; rx_byte = 8'h11; rx_ready_i = 1'b1;
      send_byte(8'h77);
      send_byte(8'h78);
      for (int i = 0; i < 200 && seq.size() < 4; i++) @(posedge clk);
      #1;
      check("rr_order", {seq[0], seq[1], seq[2], seq[3]}, "RTRT");
      stat_val = 8'h84;
      repeat (8) @(posedge clk); #1;
      rx_ready_i = 1'b0;

      // Parity error: sticky flag, STAT clear write, then explicit clear.
      stat_val = 8'hA4;
      wait_until(4, "perr_timeout");
      check("errclr_bus", {22'd0, reg_wr_o, reg_cs_stat_o, reg_d_o}, {22'd0, 2'b11, 8'h00});
      check("perr_only", {31'd0, err_frame_o}, 0);
      @(posedge clk); #1;
      stat_val = 8'h84;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("perr_sticky", {31'd0, err_parity_o}, 1);
      @(posedge clk); #1;
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      @(negedge clk);
      check("perr_cleared", {31'd0, err_parity_o}, 0);

      // Framing error while err_clr_i is held: set wins on the entry edge.
      @(posedge clk); #1;
      err_clr_i = 1'b1; stat_val = 8'h94;
      wait_until(3, "ferr_timeout");
      check("ferr_set_wins", {31'd0, err_frame_o}, 1);
      @(posedge clk); #1;
      stat_val = 8'h84;
      @(negedge clk);
      check("ferr_cleared", {31'd0, err_frame_o}, 0);
      @(posedge clk); #1;
      err_clr_i = 1'b0;

      // Runtime CTRL load and CTS reporting.
      stat_val = 8'hC4; cfg_ctrl_i = 8'h3B; cfg_load_i = 1'b1;
      @(posedge clk); #1;
      cfg_load_i = 1'b0;
      wait_until(0, "cfg_timeout");
      check("cfg_data", {24'd0, reg_d_o}, 8'h3B);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("cts", {31'd0, cts_o}, 1);
      check("tx_all_sent", tx_idx, tx_exp.size());
   endtask

   initial begin
      n_checks = 0; n_errors = 0; tx_idx = 0; tx_cnt = 0; rd_cnt = 0; last_poll = 1'b0;
      fork
         monitor();
         begin
            stimulus();
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $finish;
         end
      join_any
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
